rv_timer: RTL and testbench

//  Bus-mapped timer/capture peripheral on the rv_core data bus, decoded at ffff00a0 (32B window) alongside rv_sio/rv_pwm/rv_spi.

---
 rtl/rv_timer_if.sv | 17 +
 rtl/rv_timer.sv | 133 +++++++++++++
 tb/tb_rv_timer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_timer_if.sv
// rv_timer_if: rv_core data-bus slice seen by the timer peripheral.
//   adr  byte offset inside the 32B window (adr[4:2] picks the register)
//   cs   window select       rdy  bus ready (accesses only count when 1)
//   we   byte write enables  re   read enable
//   dw   write data          dr   registered read data, 0 when not selected
interface rv_timer_if;
   logic [4:0]  adr;
   logic        cs;
   logic        rdy;
   logic [3:0]  we;
   logic        re;
   logic [31:0] dw;
   logic [31:0] dr;

   modport master (output adr, cs, rdy, we, re, dw, input dr);
   modport slave  (input adr, cs, rdy, we, re, dw, output dr);
endinterface

// File: rtl/rv_timer.sv
// rv_timer: bus-mapped timer/capture peripheral (window ffff00a0, 32B).
//   Prescaled up-counter with compare match (optional auto-reload), overflow
//   flag and synchronised external-edge capture; level interrupt request.
// Ports:
//   clk     core clock
//   reset   synchronous, active-high
//   bus     rv_timer_if slave (adr/cs/rdy/we/re/dw in, dr out)
//   cap_in  asynchronous capture input
//   irq     registered level interrupt
// Registers: 00 CTRL{CEDGE,CIE,OIE,MIE,AUTO,EN} 04 PRESCALE 08 COUNT
//            0C COMPARE 10 STATUS{CAP,OVF,MATCH} W1C 14 CAPTURE RO
module rv_timer #(
   parameter int unsigned PRE_W = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic      clk,
   input  logic      reset,
   rv_timer_if.slave bus,
   input  logic      cap_in,
   output logic      irq
);

   typedef enum logic [2:0] {
      R_CTRL    = 3'd0,
      R_PRE     = 3'd1,
      R_COUNT   = 3'd2,
      R_COMPARE = 3'd3,
      R_STATUS  = 3'd4,
      R_CAPTURE = 3'd5,
      R_RSV6    = 3'd6,
      R_RSV7    = 3'd7
   } reg_sel_e;

   logic [5:0]       ctrl;
   logic [PRE_W-1:0] prescale;
   logic [PRE_W-1:0] pcnt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] compare;
   logic [CNT_W-1:0] capture;
   logic [2:0]       status;
   logic             sync1, sync2, sync3;

   reg_sel_e         sel;
   logic             acc, wr;
   logic [31:0]      wmask, rdata;
   logic             count_wr, tick, at_match, reload;
   logic             match_hit, ovf_hit, cap_edge;
   logic [2:0]       clr;
   logic             unused_adr;

   assign sel        = reg_sel_e'(bus.adr[4:2]);
   assign unused_adr = ^bus.adr[1:0];
   assign acc        = bus.cs & bus.rdy;
   assign wr         = acc & (|bus.we);
   assign wmask      = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [31:0] m);
      return (old & ~m) | (d & m);
   endfunction

   assign count_wr = wr & (sel == R_COUNT);
   assign tick     = ctrl[0] & (pcnt == prescale);
   assign at_match = (count == compare);
   assign reload   = at_match & ctrl[1];
   // A software COUNT write swallows the tick, so neither flag may fire then.
   assign match_hit = tick & ~count_wr & at_match;
   assign ovf_hit   = tick & ~count_wr & ~reload & (&count);
   // Edge detect between 2nd and 3rd synchroniser stages; CEDGE picks falling.
   assign cap_edge  = ctrl[5] ? (sync3 & ~sync2) : (sync2 & ~sync3);
   assign clr       = (wr & (sel == R_STATUS) & bus.we[0]) ? bus.dw[2:0] : '0;

   always_comb begin
      rdata = '0;
      case (sel)
         R_CTRL:    rdata = 32'(ctrl);
         R_PRE:     rdata = 32'(prescale);
         R_COUNT:   rdata = 32'(count);
         R_COMPARE: rdata = 32'(compare);
         R_STATUS:  rdata = 32'(status);
         R_CAPTURE: rdata = 32'(capture);
         default:   rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl     <= '0;
         prescale <= '0;
         pcnt     <= '0;
         count    <= '0;
         compare  <= '0;
         capture  <= '0;
         status   <= '0;
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync3    <= 1'b0;
         irq      <= 1'b0;
         bus.dr   <= '0;
      end else begin
         sync1 <= cap_in;
         sync2 <= sync1;
         sync3 <= sync2;

         if (wr & (sel == R_CTRL))
            ctrl <= 6'(merge(32'(ctrl), bus.dw, wmask));
         if (wr & (sel == R_PRE))
            prescale <= PRE_W'(merge(32'(prescale), bus.dw, wmask));
         if (wr & (sel == R_COMPARE))
            compare <= CNT_W'(merge(32'(compare), bus.dw, wmask));

         // Prescaler restarts on any CTRL/PRESCALE write so the new period starts cleanly.
         if ((wr & ((sel == R_CTRL) | (sel == R_PRE))) | ~ctrl[0] | tick)
            pcnt <= '0;
         else
            pcnt <= pcnt + PRE_W'(1);

         if (count_wr)
            count <= CNT_W'(merge(32'(count), bus.dw, wmask));
         else if (tick)
            count <= reload ? '0 : count + CNT_W'(1);

         if (cap_edge)
            capture <= count;

         // Hardware set dominates a same-cycle W1C.
         status <= (status & ~clr) | {cap_edge, ovf_hit, match_hit};
         irq    <= |(status & ctrl[4:2]);
         bus.dr <= (acc & bus.re) ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_rv_timer.sv
// tb_rv_timer: directed bench for rv_timer with a cycle-level reference model
// of the register map; dr and irq are checked against the model every cycle,
// and hand-computed readbacks pin the model.
module tb_rv_timer;
   localparam int unsigned PRE_W = 16;
   localparam int unsigned CNT_W = 32;
   localparam logic [4:0] A_CTRL = 5'h00, A_PRE = 5'h04, A_COUNT = 5'h08, A_CMP = 5'h0C,
                          A_STAT = 5'h10, A_CAPT = 5'h14;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cap_in = 1'b0;
   logic irq;
   rv_timer_if bus();

   rv_timer #(.PRE_W(PRE_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .bus(bus), .cap_in(cap_in), .irq(irq));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned cyc = 0;
   bit chk_en = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_ctrl, m_pre, m_cnt, m_cmp, m_stat, m_capt, m_dr;
   bit          m_irq;
   int unsigned m_phase;   // cycles elapsed in the current prescale period
   bit [3:1]    m_hist;    // cap_in as sampled 1, 2, 3 edges ago

   function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] be);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_ctrl = 0; m_pre = 0; m_cnt = 0; m_cmp = 0; m_stat = 0; m_capt = 0;
         m_dr = 0; m_irq = 0; m_phase = 0; m_hist = 0;
      end else begin
         bit wr, tick, hit, edge_seen, mset, oset;
         int sel;
         logic [32:0] sum;
         logic [31:0] view, n_cnt, n_stat;
         wr  = bus.cs && bus.rdy && (bus.we != 4'h0);
         sel = int'(bus.adr[4:2]);
         case (sel)
            0: view = m_ctrl;  1: view = m_pre;  2: view = m_cnt;
            3: view = m_cmp;   4: view = m_stat; 5: view = m_capt;
            default: view = 0;
         endcase
         m_dr  = (bus.cs && bus.re && bus.rdy) ? view : 32'h0;
         m_irq = (m_stat[0] && m_ctrl[2]) || (m_stat[1] && m_ctrl[3]) || (m_stat[2] && m_ctrl[4]);

         tick = m_ctrl[0] && (m_phase == m_pre);
         edge_seen = m_ctrl[5] ? (m_hist[3] == 1 && m_hist[2] == 0)
                               : (m_hist[3] == 0 && m_hist[2] == 1);
         mset = 0; oset = 0; n_cnt = m_cnt;
         if (wr && sel == 2) n_cnt = bytes_in(m_cnt, bus.dw, bus.we);
         else if (tick) begin
            hit = (m_cnt == m_cmp);
            mset = hit;
            sum = {1'b0, m_cnt} + 33'd1;
            if (hit && m_ctrl[1]) n_cnt = 0;
            else begin
               n_cnt = sum[31:0];
               oset = sum[32];
            end
         end
         if (edge_seen) m_capt = m_cnt;

         n_stat = m_stat;
         if (wr && sel == 4 && bus.we[0]) n_stat = n_stat & ~(bus.dw & 32'h7);
         n_stat = n_stat | {29'd0, edge_seen, oset, mset};

         if (!m_ctrl[0] || tick || (wr && (sel == 0 || sel == 1))) m_phase = 0;
         else m_phase = m_phase + 1;

         if (wr && sel == 0) m_ctrl = bytes_in(m_ctrl, bus.dw, bus.we) & 32'h3F;
         if (wr && sel == 1) m_pre  = bytes_in(m_pre, bus.dw, bus.we) & 32'hFFFF;
         if (wr && sel == 3) m_cmp  = bytes_in(m_cmp, bus.dw, bus.we);
         m_cnt  = n_cnt;
         m_stat = n_stat;
         m_hist = {m_hist[2], m_hist[1], cap_in};
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("dr_vs_model", bus.dr, m_dr);
         check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
      end
   end

   // ---------------- bus tasks (called right after a negedge) ----------------
   task automatic wr(input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] be = 4'hF, input bit r = 1);
      bus.adr = a; bus.dw = d; bus.we = be; bus.cs = 1; bus.rdy = r; bus.re = 0;
      @(negedge clk);
      bus.cs = 0; bus.we = 0; bus.rdy = 0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v, input bit r = 1);
      bus.adr = a; bus.cs = 1; bus.re = 1; bus.rdy = r; bus.we = 0;
      @(negedge clk);
      v = bus.dr;
      bus.cs = 0; bus.re = 0; bus.rdy = 0;
   endtask

   task automatic wait_irq(input bit lvl, input int lim, output bit ok);
      ok = 0;
      for (int i = 0; i < lim; i++) begin
         if (irq === lvl) begin ok = 1; break; end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] v;
      bit ok;
      int unsigned t0, t1;
      bus.adr = 0; bus.cs = 0; bus.rdy = 0; bus.we = 0; bus.re = 0; bus.dw = 0;
      reset = 1;
      repeat (3) @(negedge clk);
      chk_en = 1;
      reset = 0;

      // reset state
      for (int i = 0; i < 8; i++) begin
         rd(5'(i * 4), v);
         check("reset_read", v, 32'h0);
      end
      check("reset_irq", {31'd0, irq}, 32'h0);

      // periodic match: period (4+1)*(3+1) = 20
      wr(A_PRE, 3); wr(A_CMP, 4); wr(A_CTRL, 32'h07);
      wait_irq(1, 60, ok);
      check("periodic_first_irq", {31'd0, ok}, 32'd1);
      t0 = cyc;
      wr(A_STAT, 1);
      wait_irq(0, 10, ok);
      check("w1c_drops_irq", {31'd0, ok}, 32'd1);
      wait_irq(1, 60, ok);
      check("periodic_second_irq", {31'd0, ok}, 32'd1);
      t1 = cyc;
      check("match_period", t1 - t0, 32'd20);
      for (int i = 0; i < 6; i++) begin
         rd(A_COUNT, v);
         check("count_range", {31'd0, v < 5}, 32'd1);
      end
      wr(A_CTRL, 0); wr(A_STAT, 7); wr(A_COUNT, 0);

      // overflow: two ticks from FFFFFFFE
      wr(A_COUNT, 32'hFFFF_FFFE); wr(A_PRE, 0); wr(A_CMP, 32'h10); wr(A_CTRL, 32'h09);
      repeat (2) @(negedge clk);
      rd(A_COUNT, v);  check("ovf_count", v, 32'h0);
      rd(A_STAT, v);   check("ovf_status", v, 32'h2);
      check("ovf_irq", {31'd0, irq}, 32'd1);
      wr(A_CTRL, 0); wr(A_STAT, 7);

      // capture, rising edge
      wr(A_CMP, 32'hFFFF_0000); wr(A_CTRL, 32'h11); wr(A_COUNT, 32'h100);
      cap_in = 1;
      repeat (3) @(negedge clk);
      rd(A_CAPT, v);  check("capture_rise", v, 32'h102);
      rd(A_STAT, v);  check("capture_flag", v, 32'h4);
      check("capture_irq", {31'd0, irq}, 32'd1);
      cap_in = 0;
      repeat (5) @(negedge clk);
      wr(A_STAT, 7); wr(A_CTRL, 32'h31);
      cap_in = 1;
      repeat (5) @(negedge clk);
      rd(A_STAT, v);  check("cedge_ignores_rise", v, 32'h0);
      wr(A_COUNT, 32'h200);
      cap_in = 0;
      repeat (3) @(negedge clk);
      rd(A_CAPT, v);  check("capture_fall", v, 32'h202);
      rd(A_STAT, v);  check("capture_fall_flag", v, 32'h4);

      // collisions
      wr(A_STAT, 7); wr(A_CTRL, 32'h01);
      wr(A_COUNT, 32'h55);
      rd(A_COUNT, v);  check("count_write_wins", v, 32'h55);
      wr(A_CMP, 32'h60); wr(A_CTRL, 32'h05); wr(A_COUNT, 32'h5E);
      repeat (2) @(negedge clk);
      wr(A_STAT, 1);
      rd(A_STAT, v);  check("set_beats_w1c", v, 32'h1);
      wr(A_CTRL, 0); wr(A_STAT, 1);
      rd(A_STAT, v);  check("w1c_clears", v, 32'h0);

      // byte enables and rdy
      wr(A_CMP, 0);
      wr(A_CMP, 32'hAABB_CCDD, 4'b0010);
      rd(A_CMP, v);  check("byte_enable", v, 32'h0000_CC00);
      wr(A_CMP, 32'hFFFF_FFFF, 4'hF, 0);
      rd(A_CMP, v);  check("rdy_low_write", v, 32'h0000_CC00);
      rd(A_CMP, v, 0);  check("rdy_low_read", v, 32'h0);
      wr(A_CTRL, 32'hFFFF_FFFF);
      rd(A_CTRL, v);  check("ctrl_width", v, 32'h3F);
      wr(A_CTRL, 0);

      // reset during a read
      bus.adr = A_CMP; bus.cs = 1; bus.re = 1; bus.rdy = 1; reset = 1;
      @(negedge clk);
      check("reset_mid_read", bus.dr, 32'h0);
      bus.cs = 0; bus.re = 0; bus.rdy = 0; reset = 0;
      rd(A_CMP, v);  check("reset_clears_cmp", v, 32'h0);
      check("reset_clears_irq", {31'd0, irq}, 32'h0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
